// File: rtl/login_session_ctrl.sv
// login_session_ctrl
//   Session and lockout controller around the ID/password authentication path.
//   Gates the front-end load strobe while locked out, counts consecutive
//   failed attempts, holds a fixed-length lockout after MAX_FAIL failures,
//   and owns the logged-in session (logout on request or idle timeout).
//
//   Optional feature macro: SESSION_TIMEOUT_EN
//     defined   - idle counter present; SESSION times out after TIMEOUT_CYCLES
//     undefined - no idle counter, timeout_flag tied low, TIMEOUT_CYCLES unused
//
// Ports
//   clk            in  system clock, rising edge
//   rst            in  synchronous active-high reset
//   UserLoad       in  load pulse from front end
//   LoggedIn       in  level from authentication (password accepted)
//   auth_fail      in  pulse: authentication rejected an entry
//   activity       in  pulse: game action seen by game control
//   logout_req     in  pulse: game control requests logout
//   UserLoad_gated out load pulse to authentication (combinational)
//   logout_to_auth out registered logout pulse into authentication
//   Locked         out registered lockout indicator
//   FailCount      out registered consecutive-failure count
//   timeout_flag   out registered pulse: logout was caused by idle timeout
module login_session_ctrl #(
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCK_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UserLoad,
    input  logic       LoggedIn,
    input  logic       auth_fail,
    input  logic       activity,
    input  logic       logout_req,
    output logic       UserLoad_gated,
    output logic       logout_to_auth,
    output logic       Locked,
    output logic [2:0] FailCount,
    output logic       timeout_flag
);

    // Elaboration-time parameter sanity checks.
    if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
        $error("MAX_FAIL must be 1..7");
    end
    if (LOCK_CYCLES < 1 || (64'(LOCK_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_lock
        $error("LOCK_CYCLES must be >= 1 and fit in CNT_W bits");
    end
    if (TIMEOUT_CYCLES < 2 || (64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_LOCKED,
        ST_SESSION,
        ST_LOGOUT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
    logic [1:0]       lo_cnt, lo_cnt_next;
    logic [2:0]       fail_next;
    logic             locked_next, logout_next, tflag_next;
    logic             idle_hit;

    assign UserLoad_gated = UserLoad & ~Locked;

`ifdef SESSION_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt, idle_cnt_next;
    logic             wake;

    assign wake     = activity | UserLoad;
    // Activity in the same cycle as the timeout condition wins.
    assign idle_hit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !wake;

    always_comb begin
        idle_cnt_next = '0;
        if (state == ST_SESSION) begin
            if (wake)
                idle_cnt_next = '0;
            else if (idle_cnt != '1)
                idle_cnt_next = idle_cnt + CNT_W'(1);
            else
                idle_cnt_next = idle_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_cnt <= '0;
        else     idle_cnt <= idle_cnt_next;
    end
`else
    // Without the idle timer, activity has no consumer.
    logic unused_activity;
    assign unused_activity = activity;
    assign idle_hit        = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_OPEN;
            lock_cnt       <= '0;
            lo_cnt         <= '0;
            FailCount      <= '0;
            Locked         <= 1'b0;
            logout_to_auth <= 1'b0;
            timeout_flag   <= 1'b0;
        end else begin
            state          <= state_next;
            lock_cnt       <= lock_cnt_next;
            lo_cnt         <= lo_cnt_next;
            FailCount      <= fail_next;
            Locked         <= locked_next;
            logout_to_auth <= logout_next;
            timeout_flag   <= tflag_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        lo_cnt_next   = '0;
        fail_next     = FailCount;
        case (state)
            ST_OPEN: begin
                if (LoggedIn) begin
                    state_next = ST_SESSION;
                    fail_next  = '0;
                end else if (auth_fail) begin
                    if (3'(FailCount + 3'd1) == 3'(MAX_FAIL)) begin
                        state_next    = ST_LOCKED;
                        fail_next     = 3'(MAX_FAIL);
                        lock_cnt_next = CNT_W'(LOCK_CYCLES - 1);
                    end else begin
                        fail_next = FailCount + 3'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (lock_cnt == '0) begin
                    state_next = ST_OPEN;
                    fail_next  = '0;
                end else begin
                    lock_cnt_next = lock_cnt - CNT_W'(1);
                end
            end
            ST_SESSION: begin
                fail_next = '0;
                if (logout_req || idle_hit)
                    state_next = ST_LOGOUT;
                else if (!LoggedIn)
                    state_next = ST_OPEN;
            end
            ST_LOGOUT: begin
                // Wraps every 4 cycles; drives the periodic re-pulse.
                lo_cnt_next = lo_cnt + 2'd1;
                fail_next   = '0;
                if (!LoggedIn)
                    state_next = ST_OPEN;
            end
            default: state_next = ST_OPEN;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        locked_next = (state_next == ST_LOCKED);
        logout_next = ((state != ST_LOGOUT) && (state_next == ST_LOGOUT)) ||
                      ((state == ST_LOGOUT) && (state_next == ST_LOGOUT) && (lo_cnt == 2'd3));
`ifdef SESSION_TIMEOUT_EN
        // logout_req takes precedence, so only a pure timeout raises the flag.
        tflag_next  = (state == ST_SESSION) && (state_next == ST_LOGOUT) && !logout_req;
`else
        tflag_next  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_login_session_ctrl.sv
// Directed self-checking bench for login_session_ctrl
// (MAX_FAIL=3, LOCK_CYCLES=8, TIMEOUT_CYCLES=16).
module tb_login_session_ctrl;

    logic       clk = 1'b0;
    logic       rst, UserLoad, LoggedIn, auth_fail, activity, logout_req;
    logic       UserLoad_gated, logout_to_auth, Locked, timeout_flag;
    logic [2:0] FailCount;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    login_session_ctrl #(
        .MAX_FAIL(3),
        .LOCK_CYCLES(8),
        .TIMEOUT_CYCLES(16),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .UserLoad(UserLoad),
        .LoggedIn(LoggedIn),
        .auth_fail(auth_fail),
        .activity(activity),
        .logout_req(logout_req),
        .UserLoad_gated(UserLoad_gated),
        .logout_to_auth(logout_to_auth),
        .Locked(Locked),
        .FailCount(FailCount),
        .timeout_flag(timeout_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled on this edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_fail();
        auth_fail = 1'b1;
        step();
        auth_fail = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned lock_len;
        int unsigned pulses;

        rst = 1'b0; UserLoad = 1'b0; LoggedIn = 1'b0;
        auth_fail = 1'b0; activity = 1'b0; logout_req = 1'b0;
        do_reset();

        // Reset state
        check("rst_locked", Locked, 0);
        check("rst_failcount", FailCount, 0);
        check("rst_logout", logout_to_auth, 0);
        check("rst_tflag", timeout_flag, 0);
        UserLoad = 1'b1; #1;
        check("rst_gated", UserLoad_gated, 1);
        UserLoad = 1'b0;

        // Three failures -> lockout of exactly 8 cycles
        pulse_fail();
        check("fail1_count", FailCount, 1);
        check("fail1_locked", Locked, 0);
        pulse_fail();
        check("fail2_count", FailCount, 2);
        pulse_fail();
        check("fail3_count", FailCount, 3);
        check("fail3_locked", Locked, 1);
        lock_len = 0;
        while (Locked && lock_len < 20) begin
            lock_len++;
            if (lock_len == 2) begin
                UserLoad = 1'b1; #1;
                check("lock_gated", UserLoad_gated, 0);
                UserLoad = 1'b0;
            end
            if (lock_len == 3) auth_fail = 1'b1;
            step();
            auth_fail = 1'b0;
        end
        check("lock_length", lock_len, 8);
        check("unlock_failcount", FailCount, 0);
        check("unlock_locked", Locked, 0);

        // Reset on lockout cycle 4
        pulse_fail(); pulse_fail(); pulse_fail();
        check("relock_locked", Locked, 1);
        step(); step(); step();
        check("lock_cycle4", Locked, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midlock_rst_locked", Locked, 0);
        check("midlock_rst_failcount", FailCount, 0);
        UserLoad = 1'b1; #1;
        check("midlock_rst_gated", UserLoad_gated, 1);
        UserLoad = 1'b0;
        pulse_fail();
        check("midlock_rst_open", FailCount, 1);
        do_reset();

        // Two failures, then login clears the count; later failure does not lock
        pulse_fail(); pulse_fail();
        check("prelogin_count", FailCount, 2);
        LoggedIn = 1'b1;
        step();
        check("login_failcount", FailCount, 0);
        pulse_fail();
        check("session_fail_count", FailCount, 0);
        check("session_fail_locked", Locked, 0);
        LoggedIn = 1'b0;
        step();
        check("ext_logout_nopulse", logout_to_auth, 0);
        pulse_fail();
        check("after_session_open", FailCount, 1);
        do_reset();

        // Idle timeout
        LoggedIn = 1'b1;
        step();                         // session cycle 0
        pulses = 0;
`ifdef SESSION_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            step();
            if (logout_to_auth) pulses++;
        end
        check("pre_timeout_pulses", pulses, 0);
        step();                         // session cycle 16
        check("timeout_logout", logout_to_auth, 1);
        check("timeout_flag", timeout_flag, 1);
        step();
        check("timeout_logout_single", logout_to_auth, 0);
        check("timeout_flag_single", timeout_flag, 0);
        LoggedIn = 1'b0;
        step();
        pulse_fail();
        check("timeout_back_open", FailCount, 1);
`else
        for (int i = 1; i <= 100; i++) begin
            step();
            if (logout_to_auth || timeout_flag) pulses++;
        end
        check("no_timeout_pulses", pulses, 0);
        LoggedIn = 1'b0;
        step();
`endif
        do_reset();

        // Periodic activity keeps session alive, then logout_req
        LoggedIn = 1'b1;
        step();
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i % 10 == 0) activity = 1'b1;
            step();
            activity = 1'b0;
            if (logout_to_auth) pulses++;
        end
        check("activity_no_logout", pulses, 0);
        logout_req = 1'b1;
        step();
        logout_req = 1'b0;
        check("req_logout", logout_to_auth, 1);
        check("req_tflag", timeout_flag, 0);
        LoggedIn = 1'b0;
        step();
        check("req_logout_done", logout_to_auth, 0);
        do_reset();

        // logout_req coincident with timeout condition, then re-pulse
        LoggedIn = 1'b1;
        step();                         // session cycle 0
        for (int i = 1; i <= 15; i++) step();
        logout_req = 1'b1;              // sampled while idle count reads 15
        step();
        logout_req = 1'b0;
        check("coinc_logout", logout_to_auth, 1);
        check("coinc_tflag", timeout_flag, 0);
        pulses = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (logout_to_auth || timeout_flag) pulses++;
        end
        check("coinc_single_pulse", pulses, 0);
        step();
        check("repulse_4", logout_to_auth, 1);
        pulses = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (logout_to_auth) pulses++;
        end
        check("repulse_gap", pulses, 0);
        step();
        check("repulse_8", logout_to_auth, 1);
        LoggedIn = 1'b0;
        step();
        check("logout_exit", logout_to_auth, 0);
        pulse_fail();
        check("logout_back_open", FailCount, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/login_session_ctrl.md
# login_session_ctrl

Session and lockout controller wrapped around the authentication path (player-ID check followed by password check). It gates the user load strobe into authentication, counts consecutive failed attempts and locks input out for a fixed period after too many failures. It also owns the logged-in session: it issues the logout pulse back into authentication on a game-control request or on idle timeout. It sits between the button/keypad front end, the authentication path and game control.

## Interface
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7)
- LOCK_CYCLES, 500, lockout duration in clk cycles (≥1)
- TIMEOUT_CYCLES, 1000, idle cycles in session before forced logout (≥2)
- CNT_W, 16, width of lock and idle counters; must hold LOCK_CYCLES and TIMEOUT_CYCLES
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- UserLoad  in  1  single-cycle load pulse from front end
- LoggedIn  in  1  level from authentication; 1 = password accepted
- auth_fail  in  1  single-cycle pulse; authentication rejected an ID or password entry
- activity  in  1  single-cycle pulse from game control on any game action
- logout_req  in  1  single-cycle pulse; game control requests logout
- UserLoad_gated  out  1  load pulse forwarded to authentication
- logout_to_auth  out  1  single-cycle logout pulse into authentication
- Locked  out  1  lockout active (drives lockout LED)
- FailCount  out  3  consecutive failures in the current attempt window
- timeout_flag  out  1  single-cycle pulse when idle timeout forced the logout

## Operation
- States: OPEN, LOCKED, SESSION, LOGOUT. Reset → OPEN.
- UserLoad_gated = UserLoad & ~Locked. This path is combinational; Locked is registered.
- OPEN:
  - If LoggedIn=1 → SESSION; clear FailCount and the idle counter. This has priority over a same-cycle auth_fail.
  - Else, if auth_fail and FailCount+1 == MAX_FAIL → LOCKED. FailCount = MAX_FAIL and the lock counter is loaded with LOCK_CYCLES-1.
  - Else, auth_fail → FailCount+1.
- LOCKED:
  - Locked=1; UserLoad is dropped, not queued; auth_fail is ignored.
  - The lock counter decrements each cycle. On the cycle it reads 0 → OPEN and FailCount=0.
  - LoggedIn=1 in LOCKED is a protocol violation; it is ignored.
- SESSION:
  - The idle counter increments each cycle and clears on activity or UserLoad. It saturates and does not wrap.
  - logout_req → LOGOUT, timeout_flag=0.
  - Else, if the idle counter == TIMEOUT_CYCLES-1 and there is no activity/UserLoad this cycle → LOGOUT, timeout_flag=1.
  - Else, if LoggedIn falls (external logout) → OPEN with no logout pulse.
  - If logout_req and the timeout condition occur together: one logout, timeout_flag=0.
  - If activity and the timeout condition occur together: activity wins and the counter clears.
- LOGOUT:
  - logout_to_auth=1 on the first cycle only.
  - Remain until LoggedIn=0, then → OPEN with FailCount=0.
  - If LoggedIn is still 1 after 4 cycles in LOGOUT, re-pulse logout_to_auth, then repeat every 4 cycles.
- Reset in any state, including mid-lockout or mid-session: return to OPEN with all counters cleared on the next edge.

## Timing
- Reset values: state OPEN, Locked 0, FailCount 0, logout_to_auth 0, timeout_flag 0, counters 0. UserLoad_gated follows UserLoad.
- Lockout entry: Locked rises 1 cycle after the edge that sampled the MAX_FAIL-th auth_fail.
- Lockout length: Locked stays high for exactly LOCK_CYCLES cycles.
- Timeout: with no activity after session entry (cycle 0), logout_to_auth and timeout_flag are high on cycle TIMEOUT_CYCLES. Both are registered and high for one cycle.
- logout_req: logout_to_auth is high 1 cycle after logout_req is sampled.
- All outputs except UserLoad_gated are registered.

## Configuration
- SESSION_TIMEOUT_EN defined: the idle counter and timeout transition are present as described.
- SESSION_TIMEOUT_EN undefined:
  - No idle counter is synthesized and timeout_flag is tied to 0.
  - SESSION is left only via logout_req or LoggedIn falling.
  - TIMEOUT_CYCLES is unused.

## Test plan
All scenarios use MAX_FAIL=3, LOCK_CYCLES=8, TIMEOUT_CYCLES=16.
- Three auth_fail pulses in OPEN → FailCount steps 1,2,3; Locked=1 for exactly 8 cycles. UserLoad pulses during lockout give UserLoad_gated=0. Then FailCount=0 and Locked=0.
- Two auth_fail pulses, then LoggedIn=1 → SESSION with FailCount=0. A third auth_fail later does not lock.
- In SESSION with no activity → logout_to_auth=1 and timeout_flag=1 on cycle 16. Dropping LoggedIn returns to OPEN. With the macro undefined, no logout occurs after 100 cycles.
- In SESSION, pulse activity every 10 cycles for 100 cycles → no logout. Then logout_req → logout_to_auth 1 cycle later with timeout_flag=0.
- logout_req coincident with the timeout condition → exactly one logout_to_auth pulse and timeout_flag=0. Holding LoggedIn=1 in LOGOUT produces a re-pulse after 4 cycles.
- rst asserted on lockout cycle 4 → next cycle Locked=0, FailCount=0, state OPEN, and UserLoad passes straight through.
